irq_req_arbiter: RTL

Eight-line request front end that sits directly upstream of the 8-to-3 enabled encoder. It captures rising edges on eight asynchronous-free (already clk-synchronous) request lines into a pending register and arbitrates among them round-robin. It presents exactly one winner at a time as a registered one-hot word that drives the encoder's `w` input, and holds it until the consumer acknowledges. This guarantees the encoder never sees a multi-hot or glitching input.

---
 rtl/irq_arb_pkg.sv | 26 ++
 rtl/irq_req_arbiter_rr_pick.sv | 25 ++
 rtl/irq_req_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/irq_arb_pkg.sv
// Shared types and helpers for the interrupt request arbiter.
// Combinational helpers only; no latency, no flow control.
package irq_arb_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Assumes a one-hot input; returns 0 for an all-zero word.
  function automatic logic [IDXW-1:0] oh_idx(input logic [NREQ-1:0] oh);
    oh_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) oh_idx = IDXW'(i);
    end
  endfunction

endpackage

// File: rtl/irq_req_arbiter_rr_pick.sv
// Round-robin selector: first set pending bit at or after ptr, wrapping mod 8.
// Purely combinational (zero latency); no flow control of its own.
module rr_pick
  import irq_arb_pkg::*;
(
  input  logic [NREQ-1:0] pending,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] sel_idx
);

  logic [IDXW-1:0] cand;

  // Scan from the farthest offset down so the nearest one to ptr is written last.
  always_comb begin
    any     = |pending;
    sel_idx = ptr;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + IDXW'(i);
      if (pending[cand]) sel_idx = cand;
    end
  end

endmodule

// File: rtl/irq_req_arbiter.sv
// Edge-capturing round-robin request arbiter feeding the 8-to-3 encoder; req edge to grant is 2 cycles.
// Grant is held until ack; en_n=1 holds off new grants while pending keeps accumulating.
module irq_req_arbiter
  import irq_arb_pkg::*;
#(
  parameter int N = NREQ
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic [N-1:0] pending
);

  logic [N-1:0]    req_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  state_t          state_q, state_d;
  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic            any;
  logic [IDXW-1:0] sel_idx;

  rr_pick u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .any     (any),
    .sel_idx (sel_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!en_n && any) state_d = GRANT;
      GRANT:   if (ack)          state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    rise    = req & ~req_q;
    clr     = '0;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (!en_n && any) begin
          grant_d = onehot(sel_idx);
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        // en_n is deliberately ignored here: an issued grant always runs to ack.
        if (ack) begin
          clr     = grant_q;
          ptr_d   = oh_idx(grant_q) + 3'd1;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
    // A rise on a bit being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | rise;
  end

  assign grant   = grant_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule
